// File: rtl/bw_pkg.sv
// Shared types and widths for the bandwidth-edge path (edge finders, interpolator, bandwidth stage).
package bw_pkg;

    localparam int BW_ACCUM_W   = 16;
    localparam int BW_BIN_W     = 9;
    localparam int BW_THRESH_DB = 30;
    localparam int BW_FRAC_W    = 8;
    localparam int BW_EDGE_W    = BW_BIN_W + BW_FRAC_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CHK  = 3'd1,
        DIV  = 3'd2,
        MUL  = 3'd3,
        DONE = 3'd4
    } bw_state_e;

endpackage

// File: rtl/bw_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved on the
// start cycle so done_o flags the cycle in which the last bit is produced (Q_W >= 2).
module bw_serial_div #(
    parameter int DVD_W = 25,
    parameter int DVS_W = 17,
    parameter int Q_W   = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic [Q_W-1:0]   quot_o,
    output logic             done_o
);

    localparam int CW = $clog2(Q_W);

    logic [DVS_W-1:0] rem_q, rem_d, rem_sel;
    logic [DVS_W-1:0] dvs_q, dvs_d, dvs_sel;
    logic [Q_W-1:0]   dvd_q, dvd_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             bit_sel;
    logic [DVS_W:0]   trial;
    logic             take;

    always_comb begin
        // Caller guarantees the quotient fits Q_W bits, so the bits above the quotient
        // window are already a valid partial remainder (< divisor).
        rem_sel = start_i ? DVS_W'(dividend_i[DVD_W-1:Q_W]) : rem_q;
        bit_sel = start_i ? dividend_i[Q_W-1] : dvd_q[Q_W-1];
        dvs_sel = start_i ? divisor_i : dvs_q;
        trial   = {rem_sel, bit_sel};
        take    = (trial >= {1'b0, dvs_sel});

        rem_d  = rem_q;
        dvs_d  = dvs_q;
        dvd_d  = dvd_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i || busy_q) begin
            rem_d  = DVS_W'(take ? trial - {1'b0, dvs_sel} : trial);
            dvs_d  = dvs_sel;
            dvd_d  = start_i ? {dividend_i[Q_W-2:0], 1'b0} : {dvd_q[Q_W-2:0], 1'b0};
            quo_d  = start_i ? {{(Q_W-1){1'b0}}, take} : {quo_q[Q_W-2:0], take};
            cnt_d  = start_i ? CW'(Q_W-1) : cnt_q - CW'(1);
            busy_d = start_i ? 1'b1 : (cnt_q != CW'(1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            dvd_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            dvd_q  <= dvd_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign quot_o = quo_q;
    assign done_o = busy_q && (cnt_q == CW'(1)) && !start_i;

endmodule

// File: rtl/bw_edge_interp.sv
// Interpolates the fractional bin where the level crosses -THRESHOLD_DB between two bins.
// Build option BW_INTERP_ROUND_EN: round the interpolation fraction to nearest (halves up).
//
// state | meaning
// IDLE  | waiting for start_i, outputs hold last result
// CHK   | classify captured operands (no edge / inconsistent / divide)
// DIV   | serial divider producing the interpolation fraction
// MUL   | scale fraction by bin distance and add base bin
// DONE  | result registered; valid_o pulses on the way back to IDLE
module bw_edge_interp
    import bw_pkg::*;
#(
    parameter int ACCUM_WIDTH    = BW_ACCUM_W,
    parameter int FREQ_BIN_WIDTH = BW_BIN_W,
    parameter int THRESHOLD_DB   = BW_THRESH_DB,
    parameter int FRAC_BITS      = BW_FRAC_W
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                edge_valid_i,
    input  logic [FREQ_BIN_WIDTH-1:0]           f1_i,
    input  logic [FREQ_BIN_WIDTH-1:0]           f2_i,
    input  logic [ACCUM_WIDTH-1:0]              L1_i,
    input  logic [ACCUM_WIDTH-1:0]              L2_i,
    output logic [FREQ_BIN_WIDTH+FRAC_BITS-1:0] edge_o,
    output logic                                valid_o,
    output logic                                busy_o,
    output logic                                no_edge_o,
    output logic                                err_o
);

`ifdef BW_INTERP_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int SW    = ACCUM_WIDTH + 1;
    localparam int EW    = FREQ_BIN_WIDTH + FRAC_BITS;
    localparam int QB    = FRAC_BITS + 1;
    localparam int QW    = QB + RND;
    localparam int DVD_W = SW + FRAC_BITS + RND;

    bw_state_e                 state_q, state_d;
    logic                      ev_q, ev_d;
    logic [FREQ_BIN_WIDTH-1:0] f1_q, f1_d, f2_q, f2_d;
    logic [ACCUM_WIDTH-1:0]    l1_q, l1_d, l2_q, l2_d;
    logic [EW-1:0]             edge_q, edge_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      no_edge_q, no_edge_d;
    logic                      err_q, err_d;

    logic signed [SW-1:0]      num, den;
    logic                      chk_err;
    logic [FREQ_BIN_WIDTH-1:0] df;
    logic                      div_start, div_done;
    logic [QW-1:0]             quot;
    logic [QB-1:0]             q_use;
    logic [EW-1:0]             prod;
    logic [EW-1:0]             f1_fx;

    assign num     = {l1_q[ACCUM_WIDTH-1], l1_q} + SW'(THRESHOLD_DB);
    assign den     = {l1_q[ACCUM_WIDTH-1], l1_q} - {l2_q[ACCUM_WIDTH-1], l2_q};
    assign chk_err = num[SW-1] || den[SW-1] || (den == '0) || (f2_q < f1_q) || (num > den);
    assign df      = f2_q - f1_q;
    assign f1_fx   = {f1_q, {FRAC_BITS{1'b0}}};

    assign div_start = (state_q == CHK) && ev_q && !chk_err;

    // With rounding, one extra quotient bit carries the half-LSB.
    bw_serial_div #(
        .DVD_W (DVD_W),
        .DVS_W (SW),
        .Q_W   (QW)
    ) u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (div_start),
        .dividend_i ({num, {(FRAC_BITS+RND){1'b0}}}),
        .divisor_i  (den),
        .quot_o     (quot),
        .done_o     (div_done)
    );

`ifdef BW_INTERP_ROUND_EN
    assign q_use = QB'((quot + QW'(1)) >> 1);
`else
    assign q_use = quot;
`endif

    // q <= 2^FRAC_BITS, so the sum never exceeds f2 << FRAC_BITS.
    assign prod = EW'(q_use) * EW'(df);

    always_comb begin
        state_d   = state_q;
        ev_d      = ev_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        l1_d      = l1_q;
        l2_d      = l2_q;
        edge_d    = edge_q;
        valid_d   = 1'b0;
        no_edge_d = no_edge_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ev_d      = edge_valid_i;
                    f1_d      = f1_i;
                    f2_d      = f2_i;
                    l1_d      = L1_i;
                    l2_d      = L2_i;
                    no_edge_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = CHK;
                end
            end
            CHK: begin
                if (!ev_q) begin
                    no_edge_d = 1'b1;
                    edge_d    = '0;
                    state_d   = DONE;
                end else if (chk_err) begin
                    err_d   = 1'b1;
                    edge_d  = f1_fx;
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_done) state_d = MUL;
            end
            MUL: begin
                edge_d  = f1_fx + prod;
                state_d = DONE;
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CHK) || (state_d == DIV) || (state_d == MUL);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ev_q      <= 1'b0;
            f1_q      <= '0;
            f2_q      <= '0;
            l1_q      <= '0;
            l2_q      <= '0;
            edge_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            no_edge_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ev_q      <= ev_d;
            f1_q      <= f1_d;
            f2_q      <= f2_d;
            l1_q      <= l1_d;
            l2_q      <= l2_d;
            edge_q    <= edge_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            no_edge_q <= no_edge_d;
            err_q     <= err_d;
        end
    end

    assign edge_o    = edge_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy_q;
    assign no_edge_o = no_edge_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_bw_edge_interp.sv
// Bench for bw_edge_interp: directed vector table, hand sequences, randomized ops vs. a model.
module tb_bw_edge_interp;

    localparam int FB = 9;
    localparam int AW = 16;
    localparam int FR = 8;
    localparam int EW = FB + FR;
    localparam int T  = 30;
`ifdef BW_INTERP_ROUND_EN
    localparam bit RND   = 1'b1;
    localparam int LAT_N = FR + 5;
`else
    localparam bit RND   = 1'b0;
    localparam int LAT_N = FR + 4;
`endif
    localparam int LAT_S = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ev;
    logic [FB-1:0] f1, f2;
    logic [AW-1:0] l1, l2;
    logic [EW-1:0] edge_out;
    logic          valid, busy, no_edge, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bw_edge_interp dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .edge_valid_i (ev),
        .f1_i         (f1),
        .f2_i         (f2),
        .L1_i         (l1),
        .L2_i         (l2),
        .edge_o       (edge_out),
        .valid_o      (valid),
        .busy_o       (busy),
        .no_edge_o    (no_edge),
        .err_o        (err)
    );

    typedef struct {
        bit ev;
        int f1, f2, l1, l2;
        int e;
        bit ne, er;
        int lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Crossing rule from first principles: fraction of the bin step, scaled to FR bits.
    function automatic void model(input bit v, input int a1, input int a2, input int b1, input int b2,
                                  output int e, output bit ne, output bit er, output int lat);
        int num, den, q;
        e = 0; ne = 1'b0; er = 1'b0; lat = LAT_S;
        if (!v) begin
            ne = 1'b1;
            return;
        end
        num = b1 + T;
        den = b1 - b2;
        if (num < 0 || den <= 0 || a2 < a1 || num > den) begin
            er = 1'b1;
            e  = a1 * (1 << FR);
            return;
        end
        if (RND) q = ((num * (1 << (FR + 1))) / den + 1) / 2;
        else     q = (num * (1 << FR)) / den;
        e   = (a1 * (1 << FR) + q * (a2 - a1)) % (1 << EW);
        lat = LAT_N;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where valid is seen.
    task automatic run_op(input bit v, input int a1, input int a2, input int b1, input int b2,
                          output int e, output bit ne, output bit er, output int lat);
        ev = v; f1 = FB'(a1); f2 = FB'(a2); l1 = AW'(b1); l2 = AW'(b2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        e = int'(edge_out); ne = no_edge; er = err;
    endtask

    initial begin
        int  e, lat, a1, a2, b1, b2, me, mlat, nvalid, first_lat, first_e;
        bit  ne, er, v, mne, mer;
        logic signed [15:0] r16;

        vecs[0]  = '{1'b1, 100, 101, -20, -40, 25728, 1'b0, 1'b0, LAT_N};
        vecs[1]  = '{1'b1, 100, 101, -10, -30, 25856, 1'b0, 1'b0, LAT_N};
        vecs[2]  = '{1'b1, 100, 102, -10, -30, 26112, 1'b0, 1'b0, LAT_N};
        vecs[3]  = '{1'b0, 100, 101, -20, -40, 0,     1'b1, 1'b0, LAT_S};
        vecs[4]  = '{1'b1, 100, 101, -40, -20, 25600, 1'b0, 1'b1, LAT_S};
`ifdef BW_INTERP_ROUND_EN
        vecs[5]  = '{1'b1, 10,  11,  -28, -31, 2731,  1'b0, 1'b0, LAT_N};
`else
        vecs[5]  = '{1'b1, 10,  11,  -28, -31, 2730,  1'b0, 1'b0, LAT_N};
`endif
        vecs[6]  = '{1'b1, 101, 100, -20, -40, 25856, 1'b0, 1'b1, LAT_S};
        vecs[7]  = '{1'b1, 100, 101, -5,  -10, 25600, 1'b0, 1'b1, LAT_S};
        vecs[8]  = '{1'b1, 100, 101, -20, -20, 25600, 1'b0, 1'b1, LAT_S};
        vecs[9]  = '{1'b1, 200, 210, -30, -40, 51200, 1'b0, 1'b0, LAT_N};
        vecs[10] = '{1'b1, 300, 300, -20, -40, 76800, 1'b0, 1'b0, LAT_N};
        vecs[11] = '{1'b1, 0,   511, -10, -30, 130816, 1'b0, 1'b0, LAT_N};

        rst = 1'b1; start = 1'b0; ev = 1'b0; f1 = '0; f2 = '0; l1 = '0; l2 = '0;
        repeat (3) @(negedge clk);
        check("reset edge_o", edge_out, 0);
        check("reset valid_o", valid, 0);
        check("reset busy_o", busy, 0);
        check("reset no_edge_o", no_edge, 0);
        check("reset err_o", err, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].ev, vecs[i].f1, vecs[i].f2, vecs[i].l1, vecs[i].l2, e, ne, er, lat);
            check($sformatf("vec%0d edge", i), e, vecs[i].e);
            check($sformatf("vec%0d no_edge", i), ne, vecs[i].ne);
            check($sformatf("vec%0d err", i), er, vecs[i].er);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end

        // start re-pulsed while dividing must be ignored
        @(negedge clk);
        ev = 1'b1; f1 = 9'd100; f2 = 9'd101; l1 = AW'(-20); l2 = AW'(-40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        l1 = AW'(-10); l2 = AW'(-30); f2 = 9'd102;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nvalid = 0; first_lat = -1; first_e = -1;
        for (int n = 5; n <= 40; n++) begin
            if (valid) begin
                nvalid++;
                if (nvalid == 1) begin
                    first_lat = n;
                    first_e   = int'(edge_out);
                end
            end
            @(negedge clk);
        end
        check("repulse valid count", nvalid, 1);
        check("repulse latency", first_lat, LAT_N);
        check("repulse edge", first_e, 25728);

        // reset in the middle of a division
        ev = 1'b1; f1 = 9'd100; f2 = 9'd101; l1 = AW'(-10); l2 = AW'(-30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset busy_o", busy, 1);
        rst = 1'b1;
        #1;
        check("midreset edge_o", edge_out, 0);
        check("midreset busy_o", busy, 0);
        check("midreset valid_o", valid, 0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int n = 0; n < 20; n++) begin
            if (valid) nvalid++;
            @(negedge clk);
        end
        check("after reset no valid", nvalid, 0);
        run_op(1'b1, 100, 101, -20, -40, e, ne, er, lat);
        check("post-reset edge", e, 25728);
        check("post-reset latency", lat, LAT_N);

        // back-to-back: error result, then a new start in the cycle after DONE
        run_op(1'b1, 100, 101, -40, -20, e, ne, er, lat);
        check("b2b first err", er, 1);
        check("b2b first edge", e, 25600);
        check("b2b first latency", lat, LAT_S);
        ev = 1'b1; f1 = 9'd10; f2 = 9'd11; l1 = AW'(-10); l2 = AW'(-30);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b err cleared on accept", err, 0);
        check("b2b busy after accept", busy, 1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (valid) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
        check("b2b second latency", lat, LAT_N);
        check("b2b second edge", edge_out, 2816);
        check("b2b second err", err, 0);

        // randomized operations against the model
        for (int i = 0; i < 200; i++) begin
            v  = ($urandom_range(0, 9) != 0);
            a1 = $urandom_range(0, 511);
            if ($urandom_range(0, 3) != 0) begin
                a2 = a1 + $urandom_range(0, 4);
                if (a2 > 511) a2 = 511;
                b1 = $urandom_range(0, 45);
                b1 = b1 - T - 2;
                b2 = $urandom_range(0, 70);
                b2 = b1 - b2;
            end else begin
                a2  = $urandom_range(0, 511);
                r16 = 16'($urandom);
                b1  = r16;
                r16 = 16'($urandom);
                b2  = r16;
            end
            model(v, a1, a2, b1, b2, me, mne, mer, mlat);
            run_op(v, a1, a2, b1, b2, e, ne, er, lat);
            check($sformatf("rnd%0d edge", i), e, me);
            check($sformatf("rnd%0d no_edge", i), ne, mne);
            check($sformatf("rnd%0d err", i), er, mer);
            check($sformatf("rnd%0d latency", i), lat, mlat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
